// File: rtl/mtm_alu_arbiter.sv
// rtl/mtm_alu_arbiter.sv - two-channel round-robin arbiter in front of one mtm ALU core
module mtm_alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [2:0]  req0_OP,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req1_OP,
  output logic        core_rx_dt_ready,
  output logic [31:0] core_data_A,
  output logic [31:0] core_data_B,
  output logic [2:0]  core_data_OP,
  input  logic        core_tx_dt_ready,
  input  logic [31:0] core_data_C,
  input  logic [3:0]  core_data_flag,
  input  logic [2:0]  core_data_crc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_C,
  output logic [3:0]  rsp_flag,
  output logic [2:0]  rsp_crc,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_OP  = 2'b10;

  logic [1:0]       state;
  logic             last_grant;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [2:0]       sel_op;
  logic             op_ok;
  logic             core_drive;

  // Round-robin pick: a lone requester wins, on contention the channel not served last wins
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
    sel_a  = grant1 ? req1_A  : req0_A;
    sel_b  = grant1 ? req1_B  : req0_B;
    sel_op = grant1 ? req1_OP : req0_OP;
    op_ok  = (sel_op == 3'b000) | (sel_op == 3'b001) |
             (sel_op == 3'b100) | (sel_op == 3'b101);
  end

  assign req0_ready = (state == S_IDLE) & grant0;
  assign req1_ready = (state == S_IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  // Operands reach the core only while a request is outstanding there
  assign core_drive       = (state == S_ISSUE) | (state == S_WAIT);
  assign core_rx_dt_ready = (state == S_ISSUE);
  assign core_data_A      = core_drive ? a_q  : 32'd0;
  assign core_data_B      = core_drive ? b_q  : 32'd0;
  assign core_data_OP     = core_drive ? op_q : 3'd0;

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // Request/issue/wait/respond sequencing, result capture and fairness bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      cnt        <= '0;
      rsp_id     <= 1'b0;
      rsp_C      <= 32'd0;
      rsp_flag   <= 4'd0;
      rsp_crc    <= 3'd0;
      rsp_err    <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            rsp_id <= grant1;
            if (op_ok) begin
              state <= S_ISSUE;
            end else begin
              // Unsupported opcode: answer locally, the core never sees it
              rsp_C    <= 32'd0;
              rsp_flag <= 4'd0;
              rsp_crc  <= 3'd0;
              rsp_err  <= ERR_BAD_OP;
              state    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A result arriving on the last allowed cycle still counts as success
          if (core_tx_dt_ready) begin
            rsp_C    <= core_data_C;
            rsp_flag <= core_data_flag;
            rsp_crc  <= core_data_crc;
            rsp_err  <= ERR_OK;
            state    <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_C    <= 32'd0;
            rsp_flag <= 4'd0;
            rsp_crc  <= 3'd0;
            rsp_err  <= ERR_TIMEOUT;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// tb/tb_mtm_alu_arbiter.sv - scoreboard bench for mtm_alu_arbiter with a stub ALU core
module tb_mtm_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_OP, req1_OP;
  logic        core_rx_dt_ready, core_tx_dt_ready;
  logic [31:0] core_data_A, core_data_B, core_data_C;
  logic [2:0]  core_data_OP, core_data_crc;
  logic [3:0]  core_data_flag;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_C;
  logic [3:0]  rsp_flag;
  logic [2:0]  rsp_crc;
  logic [1:0]  rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        id;
    logic [31:0] c;
    logic [3:0]  flag;
    logic [2:0]  crc;
    logic [1:0]  err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e_mon;
  rsp_t prev;
  bit   have_prev = 0;

  int rx_count   = 0;
  int rx_start;
  bit core_en    = 1;
  int core_delay = 1;

  always #5 clk = ~clk;

  mtm_alu_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_OP(req0_OP),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_OP(req1_OP),
    .core_rx_dt_ready(core_rx_dt_ready), .core_data_A(core_data_A), .core_data_B(core_data_B),
    .core_data_OP(core_data_OP), .core_tx_dt_ready(core_tx_dt_ready), .core_data_C(core_data_C),
    .core_data_flag(core_data_flag), .core_data_crc(core_data_crc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_C(rsp_C),
    .rsp_flag(rsp_flag), .rsp_crc(rsp_crc), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] c, input logic [3:0] flag,
                            input logic [2:0] crc, input logic [1:0] err);
    rsp_t r;
    r.id = id; r.c = c; r.flag = flag; r.crc = crc; r.err = err;
    exp_q.push_back(r);
  endtask

  task automatic drive(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (ch == 0) begin
      req0_valid = 1'b1; req0_A = a; req0_B = b; req0_OP = op;
    end else begin
      req1_valid = 1'b1; req1_A = a; req1_B = b; req1_OP = op;
    end
  endtask

  // Bounded drain: DUT back in IDLE and every expected response consumed
  task automatic wait_done();
    for (int i = 0; i < 60 && (busy || exp_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check("drain", {31'd0, busy || (exp_q.size() != 0)}, 32'd0);
  endtask

  // Stub core: answers core_delay cycles after the issue strobe, computing the result itself
  initial begin
    logic [31:0] a, b, c;
    logic [2:0]  op;
    logic        cy, ov;
    core_tx_dt_ready = 1'b0; core_data_C = 32'd0; core_data_flag = 4'd0; core_data_crc = 3'd0;
    forever begin
      @(negedge clk);
      if (core_rx_dt_ready && core_en) begin
        a = core_data_A; b = core_data_B; op = core_data_OP;
        cy = 1'b0; ov = 1'b0;
        case (op)
          3'b000:  c = a & b;
          3'b001:  c = a | b;
          3'b100: begin
            {cy, c} = {1'b0, a} + {1'b0, b};
            ov = (a[31] == b[31]) && (c[31] != a[31]);
          end
          default: begin
            {cy, c} = {1'b0, a} - {1'b0, b};
            ov = (a[31] != b[31]) && (c[31] != a[31]);
          end
        endcase
        repeat (core_delay) @(posedge clk);
        #1;
        core_data_C = c;
        core_data_flag = {cy, ov, c == 32'd0, c[31]};
        core_data_crc = {a[0], b[0], op[0]};
        core_tx_dt_ready = 1'b1;
        @(posedge clk);
        #1 core_tx_dt_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) if (core_rx_dt_ready) rx_count++;

  // Monitor: stability under backpressure, then pop and compare on each handshake
  always @(negedge clk) begin
    if (rst || !rsp_valid) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        check("hold_id", {31'd0, rsp_id}, {31'd0, prev.id});
        check("hold_C", rsp_C, prev.c);
        check("hold_flag", {28'd0, rsp_flag}, {28'd0, prev.flag});
        check("hold_err", {30'd0, rsp_err}, {30'd0, prev.err});
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id %0d C %h err %b, expected none", rsp_id, rsp_C, rsp_err);
        end else begin
          e_mon = exp_q.pop_front();
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e_mon.id});
          check("rsp_C", rsp_C, e_mon.c);
          check("rsp_flag", {28'd0, rsp_flag}, {28'd0, e_mon.flag});
          check("rsp_crc", {29'd0, rsp_crc}, {29'd0, e_mon.crc});
          check("rsp_err", {30'd0, rsp_err}, {30'd0, e_mon.err});
        end
        have_prev = 0;
      end else begin
        prev.id = rsp_id; prev.c = rsp_C; prev.flag = rsp_flag; prev.crc = rsp_crc; prev.err = rsp_err;
        have_prev = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req0_A = 0; req0_B = 0; req0_OP = 0;
    req1_valid = 0; req1_A = 0; req1_B = 0; req1_OP = 0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_core_rx", {31'd0, core_rx_dt_ready}, 32'd0);
    check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Both channels contend continuously: grants alternate starting with ch0
    @(posedge clk); #1;
    rx_start = rx_count;
    drive(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000);
    drive(1, 32'h00000001, 32'h00000002, 3'b001);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_rsp(0, 32'hF000F000, 4'b0001, 3'b000, 2'b00);
      else            expect_rsp(1, 32'h00000003, 4'b0000, 3'b101, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_req0_ready", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      check("alt_req1_ready", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      if (i < 3) repeat (3) @(negedge clk);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    wait_done();
    check("alt_rx_pulses", rx_count - rx_start, 32'd4);

    // Single ADD on ch0 with nominal latency
    @(posedge clk); #1;
    rx_start = rx_count;
    drive(0, 32'hFFFFFFFF, 32'h00000001, 3'b100);
    expect_rsp(0, 32'h00000000, 4'b1010, 3'b110, 2'b00);
    @(negedge clk); check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    check("add_rx_c1", {31'd0, core_rx_dt_ready}, 32'd1);
    check("add_core_A", core_data_A, 32'hFFFFFFFF);
    check("add_core_OP", {29'd0, core_data_OP}, 32'd4);
    @(negedge clk);
    check("add_rx_c2", {31'd0, core_rx_dt_ready}, 32'd0);
    check("add_core_B_held", core_data_B, 32'd1);
    check("add_valid_c2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("add_valid_c3", {31'd0, rsp_valid}, 32'd1);
    check("add_core_A_resp", core_data_A, 32'd0);
    wait_done();
    check("add_rx_pulses", rx_count - rx_start, 32'd1);

    // Bad opcode on ch1: answered locally in cycle 1
    @(posedge clk); #1;
    rx_start = rx_count;
    drive(1, 32'h12345678, 32'h9ABCDEF0, 3'b010);
    expect_rsp(1, 32'd0, 4'd0, 3'd0, 2'b10);
    @(negedge clk); check("bad_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    check("bad_valid_c1", {31'd0, rsp_valid}, 32'd1);
    check("bad_rx", {31'd0, core_rx_dt_ready}, 32'd0);
    wait_done();
    check("bad_rx_pulses", rx_count - rx_start, 32'd0);

    // Silent core: timeout after 8 WAIT cycles, rsp_valid in cycle 10
    core_en = 0;
    @(posedge clk); #1;
    drive(0, 32'd5, 32'd3, 3'b101);
    expect_rsp(0, 32'd0, 4'd0, 3'd0, 2'b01);
    @(posedge clk); #1 req0_valid = 0;
    repeat (9) @(negedge clk);
    check("to_valid_c9", {31'd0, rsp_valid}, 32'd0);
    check("to_busy_c9", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("to_valid_c10", {31'd0, rsp_valid}, 32'd1);
    wait_done();
    core_en = 1;

    // Core answers in the final WAIT cycle: success wins over timeout
    core_delay = 8;
    @(posedge clk); #1;
    drive(0, 32'd3, 32'd5, 3'b101);
    expect_rsp(0, 32'hFFFFFFFE, 4'b1001, 3'b111, 2'b00);
    @(posedge clk); #1 req0_valid = 0;
    repeat (9) @(negedge clk);
    check("late_valid_c9", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("late_valid_c10", {31'd0, rsp_valid}, 32'd1);
    wait_done();
    core_delay = 1;

    // Backpressure: response held 5 cycles, no new request accepted meanwhile
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(1, 32'h00000010, 32'h00000001, 3'b001);
    expect_rsp(1, 32'h00000011, 4'b0000, 3'b011, 2'b00);
    @(posedge clk); #1;
    req1_valid = 0;
    drive(0, 32'h000000FF, 32'h0000000F, 3'b000);
    expect_rsp(0, 32'h0000000F, 4'b0000, 3'b110, 2'b00);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      if (i >= 2) check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("bp_next_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 0;
    wait_done();

    // Reset during WAIT: everything clears at once, late core strobe ignored
    core_delay = 3;
    @(posedge clk); #1;
    drive(0, 32'hFFFFFFFF, 32'h00000001, 3'b100);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_core_A", core_data_A, 32'd0);
    check("arst_core_rx", {31'd0, core_rx_dt_ready}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    check("arst_late_strobe_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("arst_late_strobe_valid", {31'd0, rsp_valid}, 32'd0);
    core_delay = 1;
    drive(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000);
    drive(1, 32'h00000001, 32'h00000002, 3'b001);
    expect_rsp(0, 32'hF000F000, 4'b0001, 3'b000, 2'b00);
    @(negedge clk);
    check("arst_req0_wins", {31'd0, req0_ready}, 32'd1);
    check("arst_req1_waits", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    wait_done();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtm_alu_arbiter.md
Name: mtm_alu_arbiter

Overview:
Shares one mtm ALU core between two independent operand requesters (channel 0, channel 1). Sits between the two request sources and the core's operand/result interface. Accepts one request at a time with round-robin fairness and issues it to the core as a single-cycle rx_dt_ready pulse. Captures the core's result, guards against a missing response with a timeout, rejects unsupported opcodes, and returns a tagged response on a shared valid/ready bus.

Parameters:
TIMEOUT_CYCLES, 8, number of WAIT cycles without core_tx_dt_ready before the request is aborted with a timeout error
CNT_W, 4, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  posedge clock
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  channel 0 request present
req0_ready  out  1  channel 0 request accepted this cycle
req0_A / req0_B  in  32  channel 0 operands
req0_OP  in  3  channel 0 opcode
req1_valid, req1_ready, req1_A, req1_B, req1_OP  as channel 0, for channel 1
core_rx_dt_ready  out  1  one-cycle issue strobe to core
core_data_A / core_data_B  out  32  operands to core
core_data_OP  out  3  opcode to core
core_tx_dt_ready  in  1  core result strobe
core_data_C  in  32  core result
core_data_flag  in  4  core flags {carry, overflow, zero, negative}
core_data_crc  in  3  core CRC
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_id  out  1  channel that owns the response
rsp_C  out  32  result
rsp_flag  out  4  flags
rsp_crc  out  3  CRC
rsp_err  out  2  00 ok, 01 timeout, 10 bad opcode
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 (req*_ready, core_*, rsp_*, busy). Operand/result registers 0. Timeout counter 0. last_grant=1, so channel 0 wins first. Reset mid-operation abandons the transaction; the core is not flushed, and a late core_tx_dt_ready is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and asserts only for the selected channel.
  - Selection: with a single valid, that channel. With both valid, the channel != last_grant.
  - On valid&ready: latch A, B, OP, id.
  - If OP is in {000, 001, 100, 101}: go to ISSUE.
  - Otherwise: load rsp_C=0, rsp_flag=0, rsp_crc=0, rsp_err=10 and go straight to RESP. The core is never pulsed.
- ISSUE:
  - core_rx_dt_ready=1 for exactly this one cycle.
  - core_data_A/B/OP driven from latched registers and held stable through WAIT (zero in IDLE/RESP).
  - Counter cleared. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If core_tx_dt_ready=1: capture core_data_C/flag/crc, rsp_err=00, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: load zeros, rsp_err=01, go to RESP.
  - When core_tx_dt_ready and timeout coincide, core_tx_dt_ready wins.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready.
  - On handshake: last_grant=rsp_id, go to IDLE; rsp_valid drops next cycle.
  - rsp_ready held high gives back-to-back operation.
- Core strobes outside WAIT are ignored.
- No request is accepted outside IDLE.
- Latency with a nominal core: accept in cycle 0, strobe in cycle 1, core_tx_dt_ready in cycle 2, rsp_valid from cycle 3. Steady-state throughput with rsp_ready=1 is one op per 4 cycles. A bad opcode gives rsp_valid in cycle 1.
- Widths: no arithmetic in the block other than the CNT_W-bit counter, which never wraps because it is cleared in ISSUE.

Test Plan:
- Single ADD on ch0: A=0xFFFFFFFF, B=1, OP=100 → one-cycle core_rx_dt_ready in cycle 1; rsp_valid in cycle 3 with rsp_id=0, rsp_C=0, rsp_flag=1010 (carry, zero), rsp_err=00.
- Both channels hold valid continuously with rsp_ready=1 (ch0 AND 0xF0F0F0F0&0xFF00FF00, ch1 OR 0x1|0x2) → grants alternate 0,1,0,1. Responses: rsp_C=0xF000F000 for id 0 and 0x00000003 for id 1. Exactly one rx pulse per grant.
- Bad opcode OP=010 on ch1 → core_rx_dt_ready never asserts; rsp_valid in cycle 1 with rsp_id=1, rsp_err=10, rsp_C=0.
- Stubbed core never strobes → rsp_valid after TIMEOUT_CYCLES WAIT cycles with rsp_err=01. A strobe injected in the final WAIT cycle instead yields rsp_err=00 with the captured data.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* unchanged; req*_ready=0 even with valid; on rsp_ready=1, return to IDLE and accept the next request.
- Assert rst in WAIT → all outputs 0 immediately (async); a late core_tx_dt_ready is ignored; after release, ch0 wins a simultaneous request.
